// File: rtl/fcmp_unit_if.sv
// Operand/result handshake bundle for fcmp_unit: valid/ready in, valid/ready out, tag sideband.
interface fcmp_unit_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [W-1:0]     x1;
    logic [W-1:0]     x2;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     y;
    logic [TAG_W-1:0] tag_out;
    logic             illegal_op;

    modport master (
        output in_valid, op, x1, x2, tag_in, out_ready,
        input  in_ready, out_valid, y, tag_out, illegal_op
    );

    modport slave (
        input  in_valid, op, x1, x2, tag_in, out_ready,
        output in_ready, out_valid, y, tag_out, illegal_op
    );
endinterface

// File: rtl/fcmp_unit.sv
// Float compare/min/max, STAGES cycles latency, one op per cycle.
// Backpressure: a single global stall freezes every stage while out_valid && !out_ready.
module fcmp_unit #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic        clk,
    input  logic        rstn,
    fcmp_unit_if.slave  io
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             w_advance;
    logic [W-1:0]     w_f1;
    logic [W-1:0]     w_f2;
    logic             w_eq;
    logic             w_lt;
    logic [W-1:0]     w_res;
    logic             w_ill;

    logic             r_vld [STAGES];
    logic [W-1:0]     r_y   [STAGES];
    logic [TAG_W-1:0] r_tag [STAGES];
    logic             r_ill [STAGES];

    assign w_advance   = ~io.out_valid | io.out_ready;
    assign io.in_ready = w_advance & rstn;

    // Zero exponent (denormals and -0) collapses to +0; all-ones exponent is just a big magnitude.
    assign w_f1 = (io.x1[W-2 -: EXP_W] == '0) ? '0 : io.x1;
    assign w_f2 = (io.x2[W-2 -: EXP_W] == '0) ? '0 : io.x2;

    always_comb begin
        w_eq = (w_f1 == w_f2);
        if (w_f1[W-1] != w_f2[W-1])
            w_lt = w_f1[W-1];
        else if (!w_f1[W-1])
            w_lt = (w_f1[W-2:0] < w_f2[W-2:0]);
        else
            w_lt = (w_f1[W-2:0] > w_f2[W-2:0]);
    end

    // min/max forward the raw operand bits; ties resolve to x1.
    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
        case (io.op)
            3'b000:  w_res[0] = w_eq;
            3'b001:  w_res[0] = w_lt;
            3'b010:  w_res[0] = w_lt | w_eq;
            3'b011:  w_res = (w_lt | w_eq) ? io.x1 : io.x2;
            3'b100:  w_res = w_lt ? io.x2 : io.x1;
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int s = 0; s < STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_y[s]   <= '0;
                r_tag[s] <= '0;
                r_ill[s] <= 1'b0;
            end
        end else if (w_advance) begin
            r_vld[0] <= io.in_valid;
            r_y[0]   <= w_res;
            r_tag[0] <= io.tag_in;
            r_ill[0] <= w_ill;
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_y[s]   <= r_y[s-1];
                r_tag[s] <= r_tag[s-1];
                r_ill[s] <= r_ill[s-1];
            end
        end
    end

    assign io.out_valid  = r_vld[STAGES-1];
    assign io.y          = r_y[STAGES-1];
    assign io.tag_out    = r_tag[STAGES-1];
    assign io.illegal_op = r_ill[STAGES-1];
endmodule
